// File: rtl/median_win_ctrl.sv
// median_win_ctrl: frame/line sequencer in front of the 3x3 median filter's
// two-line shift buffer. It tracks pixel/line position from the camera syncs,
// gates writes beyond the buffer depth, delays the syncs to line up with the
// 3x3 window, and reports the measured frame size plus a sticky overflow flag.
module median_win_ctrl #(
  parameter int MAX_WIDTH  = 1024,
  parameter int CW         = 11,
  parameter int MATRIX_LAT = 2
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [7:0]    per_img_y,
  output logic          lb_href,
  output logic          lb_clken,
  output logic [7:0]    lb_shiftin,
  output logic          matrix_frame_vsync,
  output logic          matrix_frame_href,
  output logic          matrix_frame_clken,
  output logic          win_valid,
  output logic          frame_done,
  output logic [CW-1:0] frame_width,
  output logic [CW-1:0] frame_height,
  output logic          err_width
);

  localparam logic [CW-1:0] MAX_COL = CW'(MAX_WIDTH);
  localparam logic [CW-1:0] ROW_MAX = '1;
  localparam logic [CW-1:0] TWO     = CW'(2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          vsync_reg;
  logic [CW-1:0] col_reg, col_next;
  logic [CW-1:0] row_reg, row_next;
  logic [CW-1:0] width_lat_reg, width_lat_next;
  logic          done_reg, done_next;
  logic [CW-1:0] fw_reg, fw_next;
  logic [CW-1:0] fh_reg, fh_next;
  logic          err_reg, err_next;
  logic          lb_href_reg, lb_clken_reg, win_in_reg;
  logic [7:0]    lb_shiftin_reg;

  logic          vsync_rise, line_open, pix_in, col_full;
  logic          pix_fwd, pix_drop, line_end, line_counts, frame_end, win_in;
  logic [CW-1:0] row_line, width_line;
  logic [3:0]    stage_in;

  // Event decode: vsync edge, line gating and per-pixel classification.
  always_comb begin
    vsync_rise  = per_frame_vsync & ~vsync_reg;
    line_open   = (state_reg != IDLE) & per_frame_href;
    pix_in      = line_open & per_frame_clken;
    col_full    = (col_reg >= MAX_COL);
    pix_fwd     = pix_in & ~col_full;
    pix_drop    = pix_in & col_full;
    line_end    = (state_reg == ACTIVE) & ~per_frame_href;
    line_counts = line_end & (col_reg != '0);
    frame_end   = vsync_rise & (state_reg != IDLE);
    win_in      = pix_fwd & (row_reg >= TWO) & (col_reg >= TWO);
    // Line end is folded in before frame end so a line closing on the
    // vsync edge still counts toward the reported height.
    row_line    = (line_counts && row_reg != ROW_MAX) ? row_reg + 1'b1 : row_reg;
    width_line  = line_counts ? col_reg : width_lat_reg;
  end

  // Next-state logic for the frame/line sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (vsync_rise) state_next = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (vsync_rise)          state_next = WAIT_LINE;
        else if (per_frame_href) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!per_frame_href || vsync_rise) state_next = WAIT_LINE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Column/row counters, frame report and sticky width error.
  always_comb begin
    col_next       = col_reg;
    row_next       = row_line;
    width_lat_next = width_line;
    done_next      = 1'b0;
    fw_next        = fw_reg;
    fh_next        = fh_reg;
    err_next       = err_reg;

    if (!per_frame_href)
      col_next = '0;
    else if (pix_in && !col_full)
      col_next = col_reg + 1'b1;

    if (frame_end) begin
      if (row_line != '0) begin
        done_next = 1'b1;
        fh_next   = row_line;
        fw_next   = width_line;
      end
      row_next       = '0;
      width_lat_next = '0;
      err_next       = 1'b0;
    end

    // A drop in the same cycle as the frame end belongs to the new frame.
    if (pix_drop) err_next = 1'b1;
  end

  // Sequencer state, counters and frame report registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      vsync_reg     <= 1'b0;
      col_reg       <= '0;
      row_reg       <= '0;
      width_lat_reg <= '0;
      done_reg      <= 1'b0;
      fw_reg        <= '0;
      fh_reg        <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      vsync_reg     <= per_frame_vsync;
      col_reg       <= col_next;
      row_reg       <= row_next;
      width_lat_reg <= width_lat_next;
      done_reg      <= done_next;
      fw_reg        <= fw_next;
      fh_reg        <= fh_next;
      err_reg       <= err_next;
    end
  end

  // Line-buffer drive: one-cycle registered, gated copies of the input.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lb_href_reg    <= 1'b0;
      lb_clken_reg   <= 1'b0;
      lb_shiftin_reg <= '0;
      win_in_reg     <= 1'b0;
    end else begin
      lb_href_reg    <= line_open;
      lb_clken_reg   <= pix_fwd;
      lb_shiftin_reg <= per_img_y;
      win_in_reg     <= win_in;
    end
  end

  assign stage_in = {vsync_reg, lb_href_reg, lb_clken_reg, win_in_reg};

  // Fixed-latency delay chain matching the window pipeline; never stalls.
  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_LAT; gi++) begin : g_stage
      logic [3:0] stage_reg;
      if (gi == 0) begin : g_first
        // First stage captures the line-buffer side signals.
        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= stage_in;
        end
      end else begin : g_next
        // Later stages shift the previous stage along.
        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, win_valid} =
         g_stage[MATRIX_LAT-1].stage_reg;

  assign lb_href      = lb_href_reg;
  assign lb_clken     = lb_clken_reg;
  assign lb_shiftin   = lb_shiftin_reg;
  assign frame_done   = done_reg;
  assign frame_width  = fw_reg;
  assign frame_height = fh_reg;
  assign err_width    = err_reg;

endmodule

// File: tb/tb_median_win_ctrl.sv
// tb_median_win_ctrl: table-driven frame scenarios, hand-written corner
// sequences and randomized frames, all checked cycle by cycle against a
// behavioural reference model kept in the bench.
module tb_median_win_ctrl;

  localparam int MAXW = 1024;
  localparam int CW   = 11;
  localparam int LAT  = 2;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [7:0]    y = '0;
  logic          lb_href, lb_clken, m_vs, m_hr, m_ck, win_valid, frame_done, err_width;
  logic [7:0]    lb_shiftin;
  logic [CW-1:0] frame_width, frame_height;

  median_win_ctrl #(.MAX_WIDTH(MAXW), .CW(CW), .MATRIX_LAT(LAT)) dut (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_y(y),
    .lb_href(lb_href), .lb_clken(lb_clken), .lb_shiftin(lb_shiftin),
    .matrix_frame_vsync(m_vs), .matrix_frame_href(m_hr), .matrix_frame_clken(m_ck),
    .win_valid(win_valid), .frame_done(frame_done),
    .frame_width(frame_width), .frame_height(frame_height), .err_width(err_width)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state: position counts derived from the sync rules.
  bit m_armed, m_pvs, m_err;
  int m_col, m_row, m_lastw, m_repw, m_reph;
  bit h_vs[LAT+1], h_lbh[LAT+1], h_ck[LAT+1], h_win[LAT+1];

  // Observed activity counters for the scenario-level checks.
  int cnt_lbck, cnt_win, cnt_done;
  bit seen_err;

  typedef struct {
    int w; int h; bit gaps;
    int exp_w; int exp_h; int exp_lbck; int exp_win; bit exp_err;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_pvs = 0; m_err = 0;
    m_col = 0; m_row = 0; m_lastw = 0; m_repw = 0; m_reph = 0;
    for (int i = 0; i <= LAT; i++) begin
      h_vs[i] = 0; h_lbh[i] = 0; h_ck[i] = 0; h_win[i] = 0;
    end
  endtask

  // One input cycle: drive at negedge, sample 1 time unit after posedge,
  // advance the model and compare the full output bundle.
  task automatic step(input bit v, input bit h, input bit c, input logic [7:0] py);
    bit rise, open, kept, drop, e_win, e_done;
    logic [7:0] e_y;
    logic [37:0] exp_v, act_v;
    @(negedge clock);
    vs = v; hr = h; ck = c; y = py;
    @(posedge clock);
    #1;
    e_done = 0;
    if (!rst_n) begin
      model_reset();
      e_y = '0;
    end else begin
      rise = v && !m_pvs;
      open = m_armed;
      kept = open && h && c && (m_col < MAXW);
      drop = open && h && c && (m_col >= MAXW);
      e_win = kept && (m_row >= 2) && (m_col >= 2);
      e_y = py;
      if (!h && m_col > 0) begin
        m_row++;
        m_lastw = m_col;
      end
      if (rise && m_armed) begin
        if (m_row > 0) begin
          e_done = 1; m_reph = m_row; m_repw = m_lastw;
        end
        m_row = 0; m_lastw = 0; m_err = 0;
      end
      if (drop) m_err = 1;
      if (rise) m_armed = 1;
      if (!h) m_col = 0;
      else if (open && c && m_col < MAXW) m_col++;
      m_pvs = v;
      for (int i = LAT; i > 0; i--) begin
        h_vs[i] = h_vs[i-1]; h_lbh[i] = h_lbh[i-1]; h_ck[i] = h_ck[i-1]; h_win[i] = h_win[i-1];
      end
      h_vs[0] = v; h_lbh[0] = open && h; h_ck[0] = kept; h_win[0] = e_win;
    end
    exp_v = {h_lbh[0], h_ck[0], e_y, h_vs[LAT], h_lbh[LAT], h_ck[LAT], h_win[LAT],
             e_done, CW'(m_repw), CW'(m_reph), m_err};
    act_v = {lb_href, lb_clken, lb_shiftin, m_vs, m_hr, m_ck, win_valid,
             frame_done, frame_width, frame_height, err_width};
    check("cycle", act_v, exp_v);
    cnt_lbck += int'(lb_clken);
    cnt_win  += int'(win_valid);
    cnt_done += int'(frame_done);
    if (err_width) seen_err = 1;
  endtask

  task automatic vsync_pulse();
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
  endtask

  // One line of w strobes; optional 1-0-1 clken gaps; optional vsync on the href fall.
  task automatic line(input int w, input bit gaps, input bit vs_on_fall);
    for (int p = 0; p < w; p++) begin
      step(0, 1, 1, 8'($urandom));
      if (gaps && p < w - 1) step(0, 1, 0, 8'($urandom));
    end
    step(vs_on_fall, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic run_frame(input int i);
    cnt_lbck = 0; cnt_win = 0; seen_err = 0;
    for (int r = 0; r < vecs[i].h; r++) line(vecs[i].w, vecs[i].gaps, 0);
    check($sformatf("vec%0d_lb_clken_count", i), 64'(cnt_lbck), 64'(vecs[i].exp_lbck));
    check($sformatf("vec%0d_win_count", i), 64'(cnt_win), 64'(vecs[i].exp_win));
    check($sformatf("vec%0d_err_seen", i), 64'(seen_err), 64'(vecs[i].exp_err));
    cnt_done = 0;
    vsync_pulse();
    check($sformatf("vec%0d_done_count", i), 64'(cnt_done), 64'd1);
    check($sformatf("vec%0d_width", i), 64'(frame_width), 64'(vecs[i].exp_w));
    check($sformatf("vec%0d_height", i), 64'(frame_height), 64'(vecs[i].exp_h));
    check($sformatf("vec%0d_err_cleared", i), 64'(err_width), 64'd0);
  endtask

  initial begin
    vecs[0] = '{w: 8,    h: 4, gaps: 0, exp_w: 8,    exp_h: 4, exp_lbck: 32,   exp_win: 12, exp_err: 0};
    vecs[1] = '{w: 4,    h: 3, gaps: 0, exp_w: 4,    exp_h: 3, exp_lbck: 12,   exp_win: 2,  exp_err: 0};
    vecs[2] = '{w: 1030, h: 1, gaps: 0, exp_w: 1024, exp_h: 1, exp_lbck: 1024, exp_win: 0,  exp_err: 1};
    vecs[3] = '{w: 6,    h: 3, gaps: 1, exp_w: 6,    exp_h: 3, exp_lbck: 18,   exp_win: 4,  exp_err: 0};
    vecs[4] = '{w: 5,    h: 5, gaps: 0, exp_w: 5,    exp_h: 5, exp_lbck: 25,   exp_win: 9,  exp_err: 0};

    model_reset();
    cnt_lbck = 0; cnt_win = 0; cnt_done = 0; seen_err = 0;

    // Reset state.
    step(0, 0, 0, 0); step(1, 1, 1, 8'h5a); step(0, 0, 0, 0);
    check("reset_outputs",
          {lb_href, lb_clken, lb_shiftin, m_vs, m_hr, m_ck, win_valid, frame_done,
           frame_width, frame_height, err_width}, 64'd0);
    rst_n = 1'b1;

    // Pixels before the first vsync are not forwarded.
    cnt_lbck = 0; cnt_done = 0;
    line(4, 0, 0);
    check("pre_vsync_lb_clken", 64'(cnt_lbck), 64'd0);
    check("pre_vsync_done", 64'(cnt_done), 64'd0);
    vsync_pulse();
    check("first_vsync_no_done", 64'(cnt_done), 64'd0);

    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        // Reset asserted in the middle of row 1.
        line(7, 0, 0);
        step(0, 1, 1, 8'h11); step(0, 1, 1, 8'h22); step(0, 1, 1, 8'h33);
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {lb_href, lb_clken, lb_shiftin, m_vs, m_hr, m_ck, win_valid, frame_done,
               frame_width, frame_height, err_width}, 64'd0);
        step(0, 1, 1, 8'h44); step(0, 1, 1, 8'h55);
        rst_n = 1'b1;
        cnt_lbck = 0; cnt_done = 0;
        step(0, 1, 1, 8'h66); step(0, 1, 1, 8'h77); step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("post_reset_gated", 64'(cnt_lbck), 64'd0);
        vsync_pulse();
        check("post_reset_vsync_no_done", 64'(cnt_done), 64'd0);
      end
      run_frame(i);
    end

    // Second vsync with no lines: empty frame, no pulse.
    cnt_done = 0;
    vsync_pulse();
    check("empty_frame_no_done", 64'(cnt_done), 64'd0);

    // Vsync rising together with the href fall of the last line.
    line(3, 0, 0);
    cnt_done = 0;
    line(3, 0, 1);
    check("sim_edge_done_count", 64'(cnt_done), 64'd1);
    check("sim_edge_height", 64'(frame_height), 64'd2);
    check("sim_edge_width", 64'(frame_width), 64'd3);

    // Randomized frames against the model.
    vsync_pulse();
    for (int f = 0; f < 8; f++) begin
      int nl, lw;
      nl = $urandom_range(1, 6);
      lw = 0;
      for (int r = 0; r < nl; r++) begin
        lw = $urandom_range(1, 20);
        for (int p = 0; p < lw; p++) begin
          step(0, 1, 1, 8'($urandom));
          if (p < lw - 1) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) step(0, 1, 0, 8'($urandom));
          end
        end
        for (int k = 0; k < $urandom_range(1, 4); k++)
          step(0, 0, 1'($urandom), 8'($urandom));
      end
      cnt_done = 0;
      vsync_pulse();
      check($sformatf("rand%0d_done_count", f), 64'(cnt_done), 64'd1);
      check($sformatf("rand%0d_width", f), 64'(frame_width), 64'(lw));
      check($sformatf("rand%0d_height", f), 64'(frame_height), 64'(nl));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_win_ctrl.md
# median_win_ctrl

Frame/line sequencer placed in front of the 3x3 median filter's two-line shift buffer. It tracks frame, line and pixel position from the camera-side sync signals and drives the buffer's `clken`/`href` inputs, gating pixels beyond the buffer depth. It delays the sync signals to match the window pipeline and flags which outputs carry a fully populated 3x3 window. Per frame it reports the measured width and height, plus a sticky overflow error.

## Interface
- `MAX_WIDTH`, 1024: line buffer depth in pixels. Pixels at column index >= MAX_WIDTH are not written.
- `CW`, 11: width of the column and row counters. Must satisfy 2^CW > MAX_WIDTH.
- `MATRIX_LAT`, 2: cycles from `lb_*` outputs to a valid 3x3 window at the filter input.
- `clock`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `per_frame_vsync`  in  1  frame sync, active high; its rising edge marks a frame boundary.
- `per_frame_href`  in  1  line valid, active high.
- `per_frame_clken`  in  1  pixel strobe; qualified by `href`.
- `per_img_y`  in  8  pixel luma.
- `lb_href`  out  1  to line buffer `per_frame_href`.
- `lb_clken`  out  1  to line buffer `clken`; gated.
- `lb_shiftin`  out  8  to line buffer `shiftin`.
- `matrix_frame_vsync`  out  1  vsync aligned to the window.
- `matrix_frame_href`  out  1  href aligned to the window.
- `matrix_frame_clken`  out  1  clken aligned to the window.
- `win_valid`  out  1  the window at this `matrix_frame_clken` lies fully inside the image.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `frame_width`  out  CW  pixels in the last line of the finished frame.
- `frame_height`  out  CW  lines in the finished frame.
- `err_width`  out  1  sticky flag: a line exceeded MAX_WIDTH in the current frame.

## Operation
- **FSM states:** IDLE, WAIT_LINE, ACTIVE.
- **IDLE (after reset):**
  - All gating is closed: `lb_href` and `lb_clken` are 0.
  - On a vsync rising edge the FSM goes to WAIT_LINE. Frame_done is not pulsed for this edge.
- **WAIT_LINE:**
  - On href=1, go to ACTIVE.
  - On a vsync rising edge, finish the frame (see frame end) and stay in WAIT_LINE.
- **ACTIVE:**
  - On href=0, go to WAIT_LINE.
  - At that transition, if `col` > 0: set `row <= row+1` and latch `width_lat <= col`.
  - A vsync rising edge while href=1 is a protocol error. It is treated as frame end and the FSM goes to WAIT_LINE.
- **Column counter `col`:**
  - Cleared whenever href=0.
  - In ACTIVE, `col` increments on each `clken` and saturates at MAX_WIDTH.
- **Pixel gating:**
  - A pixel with `col` < MAX_WIDTH is forwarded with `lb_clken`=1.
  - A pixel with `col` >= MAX_WIDTH is dropped (`lb_clken`=0) and sets `err_width`.
- **Frame end (vsync rising edge, not from IDLE):**
  - If `row` > 0: pulse `frame_done` and load `frame_height <= row`, `frame_width <= width_lat`.
  - Then clear `row`, `width_lat` and `err_width`.
  - A frame with zero lines produces no pulse.
- **`win_valid`:** equals (`row` >= 2) AND (pixel `col` index >= 2), evaluated at input time and delayed with the pixel. It is 0 on rows 0-1 and columns 0-1; the filter replaces those with the pass-through pixel.
- **Simultaneous events:**
  - vsync rising edge in the same cycle as href falling: line end is processed first, then frame end. The finishing line counts in `frame_height`.
  - clken while href=0: ignored.

## Timing
- `lb_href`, `lb_clken`, `lb_shiftin`: registered copies of the inputs, 1 cycle latency.
- `matrix_frame_*` and `win_valid`: delayed a further MATRIX_LAT cycles, so 1+MATRIX_LAT cycles after the input (3 by default). They use a shift-register chain with no gaps and no dependence on stalls.
- `frame_done`, `frame_width`, `frame_height`: update 1 cycle after the vsync rising edge is sampled. The width/height values stay stable until the next `frame_done`.
- `err_width`: set 1 cycle after the first dropped pixel.
- **Reset values:** all outputs and delay-chain stages are 0, counters are 0, FSM is IDLE.
- **Reset asserted mid-line:** all outputs drop to 0 immediately (asynchronously). Processing resumes only after the next vsync rising edge following reset release.
- **Edge detection:** one registered vsync sample. An edge is rising when the current sample is 1 and the previous is 0.

## Test plan
- **Reset, then an 8x4 frame with continuous clken:**
  - `lb_clken` lags input clken by 1 cycle; `matrix_frame_clken` lags it by 3.
  - `win_valid` = 1 only for rows 2-3, columns 2-7 (12 pixels).
  - `frame_done` pulses with width=8, height=4.
- **Pixels before the first vsync after reset:** `lb_clken` stays 0 and there is no `frame_done`. After a vsync edge and a 4x3 frame: width=4, height=3.
- **Line of 1030 pixels with MAX_WIDTH=1024:**
  - Exactly 1024 `lb_clken` pulses.
  - `err_width` rises on pixel 1025 and clears after the next frame end.
  - `frame_width` = 1024.
- **Clken toggling 1-0-1 within a 6-pixel line:** `col` advances only on strobes, `frame_width`=6, and the `matrix_*` chain preserves the gaps.
- **Two consecutive vsync edges with no lines between them:** a single `frame_done` for the earlier real frame and none for the empty frame.
- **`rst_n` low for 2 cycles in mid-line of row 1:**
  - Outputs are 0 during reset.
  - The next frame (5x5) reports height=5, not a carried-over count.
